// File: rtl/async_fifo_arb_pkg.sv
// Shared types and constants for the async FIFO write-side arbiter.
//   arb_state_e : arbiter FSM states
//   STAT_W      : width of each per-requester accepted-word counter
//   rr_next     : circular successor of a requester index
package async_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  localparam int STAT_W = 32;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Combinational circular priority picker. The search starts at rr_ptr and
// wraps around, returning the first set bit of req.
// Ports:
//   req         in  NUM_REQ  request vector
//   rr_ptr      in  PTR_W    index where the search starts
//   pick_onehot out NUM_REQ  one-hot winner, 0 if no request
//   pick_idx    out PTR_W    winner index, 0 if no request
//   pick_vld    out 1        at least one request set
module async_fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_vld
);

  int j;

  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_vld    = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld       = 1'b1;
        pick_onehot[j] = 1'b1;
        pick_idx       = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Write-side scheduler for the async FIFO. Shares the single FIFO write port
// among NUM_REQ requesters with burst-based round-robin arbitration, aborts
// bursts whose owner goes quiet, and keeps a sticky overflow flag.
// Optional build macro: ASYNC_FIFO_ARB_STATS_EN adds per-requester
// saturating accepted-word counters on stat_words (tied to 0 otherwise).
// Ports:
//   wclk, sw_rst         clock, synchronous active-high reset
//   req_valid/last/data  requester side (data packed, DATA_WIDTH per requester)
//   req_ready            per-requester accept
//   wdata, write_enable  FIFO write port
//   afull_value          constant almost-full threshold to FIFO
//   wfull, wr_almost_ful FIFO flow control
//   overflow             FIFO overflow indication
//   grant                one-hot burst owner, 0 when idle
//   burst_abort          one-cycle pulse when a burst times out
//   ovf_err              sticky overflow flag
//   stat_words           per-requester accepted-word counts
//
// state     | meaning
// ARB_IDLE  | no owner; arbitrate among valid requesters when FIFO has room
// ARB_BURST | owner streams up to BURST_LEN beats, stalls on wfull
module async_fifo_wr_arb
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int BURST_LEN     = 8,
  parameter int IDLE_TIMEOUT  = 4,
  parameter int AFULL_LEVEL   = 20
) (
  input  logic                          wclk,
  input  logic                          sw_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          write_enable,
  output logic [ADDRESS_WIDTH-1:0]      afull_value,
  input  logic                          wfull,
  input  logic                          wr_almost_ful,
  input  logic                          overflow,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          burst_abort,
  output logic                          ovf_err,
  output logic [NUM_REQ*STAT_W-1:0]     stat_words
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               abort_q, abort_d;
  logic               ovf_q;
  logic               acc;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_vld;

  async_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_pick (
    .req         (req_valid),
    .rr_ptr      (rr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_vld    (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    abort_d      = 1'b0;
    acc          = 1'b0;
    req_ready    = '0;
    wdata        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_vld && !wfull && !wr_almost_ful) begin
          state_d = ARB_BURST;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          rr_d    = PW'(rr_next(int'(pick_idx), NUM_REQ));
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      ARB_BURST: begin
        wdata     = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        req_ready = grant_q & {NUM_REQ{!wfull}};
        // Reset wins over an in-flight handshake so no beat is lost silently.
        acc       = req_valid[owner_q] && !wfull && !sw_rst;
        if (acc) begin
          beat_d = beat_q + BW'(1);
          idle_d = '0;
          if (req_last[owner_q] || beat_q == BEAT_MAX) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            beat_d  = '0;
          end
        end else if (!wfull && !req_valid[owner_q]) begin
          if (idle_q == IDLE_MAX) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            beat_d  = '0;
            idle_d  = '0;
            abort_d = 1'b1;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (sw_rst) begin
      req_ready = '0;
    end
    write_enable = acc;
  end

  always_ff @(posedge wclk) begin
    if (sw_rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      abort_q <= abort_d;
      if (overflow) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign burst_abort = abort_q;
  assign ovf_err     = ovf_q;
  assign afull_value = ADDRESS_WIDTH'(AFULL_LEVEL);

`ifdef ASYNC_FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge wclk) begin
      if (sw_rst) begin
        cnt_q <= '0;
      end else if (acc && owner_q == PW'(i) && cnt_q != '1) begin
        cnt_q <= cnt_q + STAT_W'(1);
      end
    end
    assign stat_words[i*STAT_W +: STAT_W] = cnt_q;
  end
`else
  assign stat_words = '0;
`endif

endmodule
